alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 11 +
 rtl/alu_arbiter_xor_alu.sv | 14 +
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port XOR arbiter: FSM encoding and default operand width.
`timescale 1ns/1ps
package alu_arbiter_pkg;
    localparam int WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_arbiter_xor_alu.sv
// Combinational XOR unit; rst forces a zero result.
`timescale 1ns/1ps
module xor_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = rst ? '0 : (a ^ b);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters a shared XOR ALU through an IDLE/EXEC/RESP FSM.
`timescale 1ns/1ps
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);
    state_t           state, state_nxt;
    logic             last;
    logic             pick;
    logic             any_req;
    logic [WIDTH-1:0] op_a, op_b, alu_y;

    // last doubles as the winner of the operation in flight
    always_comb begin
        state_nxt = state;
        any_req   = req0 | req1;
        pick      = (req0 && req1) ? ~last : req1;
        case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            ops_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a <= pick ? a1 : a0;
                        op_b <= pick ? b1 : b0;
                        gnt0 <= ~pick;
                        gnt1 <= pick;
                        last <= pick;
                    end
                end
                EXEC: begin
                    result <= alu_y;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    done0  <= ~last;
                    done1  <= last;
                    if (ops_count != '1) ops_count <= ops_count + CNT_W'(1);
                end
                RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

    xor_alu #(.WIDTH(WIDTH)) u_alu (
        .rst (1'b0),
        .a   (op_a),
        .b   (op_b),
        .y   (alu_y)
    );
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors plus a randomized exclusivity/XOR soak.
`timescale 1ns/1ps
module tb_alu_arbiter;
    typedef struct {
        logic       port;
        logic [2:0] res;
        int         cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [2:0] result;
    logic [7:0] ops_count;
    logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy;
    logic [2:0] s_result;
    logic [1:0] ops_count2;

    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   exp_count = 0;
    bit   sb_en = 1'b1;
    bit   exact_gap = 1'b0;
    exp_t sb[$];

    alu_arbiter #(.WIDTH(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result),
        .busy(busy), .ops_count(ops_count)
    );

    alu_arbiter #(.WIDTH(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1), .result(s_result),
        .busy(s_busy), .ops_count(ops_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic p, input logic [2:0] r);
        exp_t e;
        exp_count++;
        e.port = p;
        e.res  = r;
        e.cnt  = exp_count;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        exp_count = 0;
        sb.delete();
        rst = 1'b1;
    endtask

    initial begin
        fork
            begin : monitor
                exp_t       e;
                int         cyc = 0;
                int         last_cyc = 0;
                bit         have_gnt = 1'b0;
                logic       gpend_port = 1'b0;
                logic [2:0] gpend_x = '0;
                logic [2:0] a0_d = '0, b0_d = '0, a1_d = '0, b1_d = '0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (rst) begin
                        if (gnt0 | gnt1) begin
                            check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
                            gpend_port = gnt1;
                            gpend_x    = gnt1 ? (a1_d ^ b1_d) : (a0_d ^ b0_d);
                            if (have_gnt) begin
                                if (exact_gap) check("gnt_gap", 32'(cyc - last_cyc), 32'd3);
                                else           check("gnt_gap_min", 32'(cyc - last_cyc >= 3), 32'd1);
                            end
                            have_gnt = 1'b1;
                            last_cyc = cyc;
                        end
                        if (done0 | done1) begin
                            check("done_excl", 32'(done0 & done1), 32'd0);
                            check("done_port", 32'(done1), 32'(gpend_port));
                            check("result_xor", 32'(result), 32'(gpend_x));
                            if (sb_en) begin
                                if (sb.size() == 0) begin
                                    chk_cnt++;
                                    $display("FAIL sb_unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
                                end else begin
                                    e = sb.pop_front();
                                    check("sb_port", 32'(done1), 32'(e.port));
                                    check("sb_result", 32'(result), 32'(e.res));
                                    check("sb_count", 32'(ops_count), 32'(e.cnt));
                                    check("sat_count", 32'(ops_count2), 32'((e.cnt > 3) ? 3 : e.cnt));
                                end
                            end
                        end
                    end else begin
                        have_gnt = 1'b0;
                    end
                    a0_d = a0; b0_d = b0; a1_d = a1; b1_d = b1;
                end
            end
        join_none

        // reset state
        tick(2);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(ops_count), 32'd0);
        rst = 1'b1;
        tick(2);
        check("idle_hold_busy", 32'(busy), 32'd0);

        // single request on port 0
        req0 = 1'b1; a0 = 3'b001; b0 = 3'b011;
        push(1'b0, 3'b010);
        tick(1);
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_gnt1", 32'(gnt1), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        tick(1);
        check("t1_done0", 32'(done0), 32'd1);
        check("t1_gnt0_clr", 32'(gnt0), 32'd0);
        tick(4);

        // contention after reset: alternate starting with port 0
        do_reset();
        exact_gap = 1'b1;
        req0 = 1'b1; a0 = 3'b101; b0 = 3'b001;
        req1 = 1'b1; a1 = 3'b010; b1 = 3'b110;
        push(1'b0, 3'b100);
        push(1'b1, 3'b100);
        push(1'b0, 3'b100);
        push(1'b1, 3'b100);
        tick(10);
        req0 = 1'b0; req1 = 1'b0;
        tick(4);
        exact_gap = 1'b0;

        // operands change and req drops during EXEC
        req1 = 1'b1; a1 = 3'b100; b1 = 3'b001;
        push(1'b1, 3'b101);
        tick(1);
        check("t3_gnt1", 32'(gnt1), 32'd1);
        a1 = 3'b111; req1 = 1'b0;
        tick(1);
        check("t3_done1", 32'(done1), 32'd1);
        tick(5);
        check("t3_result_hold", 32'(result), 32'd5);

        // reset in the middle of an operation
        req0 = 1'b1; a0 = 3'b111; b0 = 3'b111;
        tick(1);
        check("t4_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b0;
        #1;
        check("t4_gnt0_abort", 32'(gnt0), 32'd0);
        check("t4_busy_abort", 32'(busy), 32'd0);
        check("t4_result_abort", 32'(result), 32'd0);
        check("t4_count_abort", 32'(ops_count), 32'd0);
        check("t4_sat_abort", 32'(ops_count2), 32'd0);
        req0 = 1'b0;
        tick(2);
        exp_count = 0;
        rst = 1'b1;
        tick(4);
        check("t4_count_after", 32'(ops_count), 32'd0);
        check("t4_done0_after", 32'(done0), 32'd0);

        // random soak: exclusivity and XOR of granted operands
        sb_en = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            a0 = 3'($urandom); b0 = 3'($urandom);
            a1 = 3'($urandom); b1 = 3'($urandom);
            tick(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(5);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
